// File: rtl/rx_4b6b_decoder.sv
// rx_4b6b_decoder: oversampling 4b6b line decoder; locks on SOF after a guard gap
// and emits one byte per pair of data codewords.
module rx_4b6b_decoder #(
  parameter int CHIP_CYCLES  = 100,
  parameter int GUARD_CYCLES = 800
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       dataValid,
  output logic       rx_err,
  output logic       rx_busy
);
  localparam int CW = $clog2(CHIP_CYCLES);
  localparam logic [CW-1:0] HALF = CW'(CHIP_CYCLES / 2);
  localparam logic [CW-1:0] LAST = CW'(CHIP_CYCLES - 1);
  localparam logic [5:0] SOF_SYM = 6'b111000;
  localparam logic [5:0] EOF_SYM = 6'b000111;
  typedef enum logic [2:0] {HUNT, ARMED, SOF, HI, LO} state_t;
  state_t state, state_n;
  logic s1, rxs, rxs_d;
  logic [CW-1:0] chipcnt;
  logic [15:0] lowcnt;
  logic [4:0] sym;
  logic [2:0] idx;
  logic [3:0] hi, hi_n;
  logic [7:0] byte_n;
  logic dv_n, err_n;
  logic edg, rise, sample, collecting, done;
  logic [5:0] sym_full;
  logic [4:0] d;
  function automatic logic [4:0] dec(input logic [5:0] c);
    case (c)
      6'b001110: dec = {1'b1, 4'h0};
      6'b001101: dec = {1'b1, 4'h1};
      6'b010011: dec = {1'b1, 4'h2};
      6'b010110: dec = {1'b1, 4'h3};
      6'b010101: dec = {1'b1, 4'h4};
      6'b100011: dec = {1'b1, 4'h5};
      6'b100110: dec = {1'b1, 4'h6};
      6'b100101: dec = {1'b1, 4'h7};
      6'b011001: dec = {1'b1, 4'h8};
      6'b011010: dec = {1'b1, 4'h9};
      6'b011100: dec = {1'b1, 4'hA};
      6'b110001: dec = {1'b1, 4'hB};
      6'b110010: dec = {1'b1, 4'hC};
      6'b101001: dec = {1'b1, 4'hD};
      6'b101010: dec = {1'b1, 4'hE};
      6'b101100: dec = {1'b1, 4'hF};
      default:   dec = 5'd0;
    endcase
  endfunction
  assign edg        = rxs ^ rxs_d;
  assign rise       = rxs & ~rxs_d;
  // an edge landing on the sample point re-phases instead of sampling
  assign sample     = (chipcnt == HALF) && !edg;
  assign collecting = state inside {SOF, HI, LO};
  assign done       = collecting && sample && (idx == 3'd5);
  assign sym_full   = {sym, rxs};
  assign d          = dec(sym_full);
  assign rx_busy    = collecting;
  always_comb begin
    state_n = state;
    hi_n    = hi;
    byte_n  = data_o;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      HUNT:  if (lowcnt >= 16'(GUARD_CYCLES)) state_n = rise ? SOF : ARMED;
      ARMED: if (rise) state_n = SOF;
      SOF:   if (done) state_n = (sym_full == SOF_SYM) ? HI : HUNT;
      HI: if (done) begin
        hi_n    = d[4] ? d[3:0] : hi;
        state_n = d[4] ? LO : HUNT;
        err_n   = !d[4] && (sym_full != EOF_SYM);
      end
      LO: if (done) begin
        byte_n  = d[4] ? {hi, d[3:0]} : data_o;
        dv_n    = d[4];
        err_n   = !d[4];
        state_n = d[4] ? HI : HUNT;
      end
      default: state_n = HUNT;
    endcase
  end
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      s1        <= 1'b0;
      rxs       <= 1'b0;
      rxs_d     <= 1'b0;
      chipcnt   <= '0;
      lowcnt    <= '0;
      sym       <= '0;
      idx       <= '0;
      hi        <= '0;
      state     <= HUNT;
      data_o    <= 8'h00;
      dataValid <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      s1        <= rx;
      rxs       <= s1;
      rxs_d     <= rxs;
      chipcnt   <= (edg || chipcnt == LAST) ? '0 : chipcnt + CW'(1);
      // lowcnt is held at zero outside HUNT so every entry starts a fresh guard
      lowcnt    <= (state == HUNT && !rxs) ? (lowcnt == 16'hFFFF ? lowcnt : lowcnt + 16'd1) : 16'd0;
      sym       <= sample ? sym_full[4:0] : sym;
      idx       <= !collecting ? 3'd0 : !sample ? idx : (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      hi        <= hi_n;
      state     <= state_n;
      data_o    <= byte_n;
      dataValid <= dv_n;
      rx_err    <= err_n;
    end
  end
endmodule
